// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder controller.
// Holds the controller state encoding, the slice width and a helper that
// sizes the nibble index counter.
package adder_pkg;

    // Controller states: waiting for operands, adding nibbles, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the shared carry-select slice.
    localparam int NIBBLE_W = 4;

    // Bits needed to count nibbles 0..nib-1. Never returns less than 1,
    // so a single-nibble build still gets a legal counter.
    function automatic int idx_width(input int nib);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< w) < nib) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Handshake bus of the nibble-serial adder.
// master drives operands (in_valid, a, b, cin) and out_ready;
// slave (the adder) drives in_ready and the result (out_valid, sum, cout, ovf).
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/csa4_slice.sv
// Combinational 4-bit carry-select adder slice.
// Ports: a, b - nibble operands; cin - carry in; s - nibble sum; cout - carry out.
// Both carry-in cases are computed in parallel and cin only drives the final mux.
module csa4_slice
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);
    logic [NIBBLE_W:0] sum0_s;
    logic [NIBBLE_W:0] sum1_s;

    assign sum0_s = {1'b0, a} + {1'b0, b};
    assign sum1_s = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, 1'b1};

    // Select the precomputed result matching the incoming carry.
    always_comb begin
        s    = sum0_s[NIBBLE_W-1:0];
        cout = sum0_s[NIBBLE_W];
        if (cin) begin
            s    = sum1_s[NIBBLE_W-1:0];
            cout = sum1_s[NIBBLE_W];
        end else begin
            s    = sum0_s[NIBBLE_W-1:0];
            cout = sum0_s[NIBBLE_W];
        end
    end
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder: adds two WIDTH-bit operands one nibble per clock,
// LSB first, through a single shared 4-bit carry-select slice.
// Ports: clk - rising-edge clock; rst - asynchronous active-high reset;
//        bus - slave side of the operand/result handshake interface.
// Operands are accepted in IDLE, RUN takes WIDTH/4 cycles, and DONE holds the
// registered sum/cout/ovf until the consumer takes them.
module nibble_serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_e              state_r;
    logic [IDX_W-1:0]    idx_r;
    logic                carry_r;
    logic [WIDTH-1:0]    a_r;
    logic [WIDTH-1:0]    b_r;
    logic [WIDTH-1:0]    sum_r;
    logic                cout_r;
    logic                ovf_r;
    logic                out_valid_r;
    logic                in_ready_r;

    logic [NIBBLE_W-1:0] a_nib_s;
    logic [NIBBLE_W-1:0] b_nib_s;
    logic [NIBBLE_W-1:0] slice_sum_s;
    logic                slice_cout_s;

    // Pick the operand nibbles addressed by the index counter.
    always_comb begin
        a_nib_s = a_r[idx_r*NIBBLE_W +: NIBBLE_W];
        b_nib_s = b_r[idx_r*NIBBLE_W +: NIBBLE_W];
    end

    csa4_slice u_slice (
        .a    (a_nib_s),
        .b    (b_nib_s),
        .cin  (carry_r),
        .s    (slice_sum_s),
        .cout (slice_cout_s)
    );

    // Controller FSM with index counter, operand/carry/result registers and handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            carry_r     <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.a;
                        b_r        <= bus.b;
                        carry_r    <= bus.cin;
                        idx_r      <= '0;
                        sum_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    sum_r[idx_r*NIBBLE_W +: NIBBLE_W] <= slice_sum_s;
                    carry_r <= slice_cout_s;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (idx_r == LAST_IDX) begin
                        // Overflow: equal operand signs but the new MSB differs from them.
                        cout_r      <= slice_cout_s;
                        ovf_r       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                       (slice_sum_s[NIBBLE_W-1] != a_r[WIDTH-1]);
                        idx_r       <= '0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
endmodule
